// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported unified memory between the fetch stage (read-only)
// and the memory-access stage (read/write). Only one transaction is in flight
// at a time. Data accesses win arbitration, except when the data side has
// already taken MAX_STREAK consecutive grants while fetch was waiting; then
// fetch is served once.
//
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   if_req/if_addr  : fetch read request (held until if_rvalid)
//   if_rdata        : fetch read data (mem_rdata passed through)
//   if_rvalid       : fetch completion pulse
//   ma_req/ma_we/ma_addr/ma_wdata : data request (held until ma_done),
//                     ma_we == 4'b0000 means read
//   ma_rdata        : load data (mem_rdata passed through)
//   ma_done         : data completion pulse
//   mem_req/mem_addr/mem_we/mem_wdata : registered request towards memory
//   mem_gnt         : memory accepted mem_req this cycle
//   mem_rvalid/mem_rdata : memory completion and read data
//   stall_if/stall_ma    : per-stage hold signals for the pipeline controller
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_rvalid,

    input  logic              ma_req,
    input  logic [3:0]        ma_we,
    input  logic [ADDR_W-1:0] ma_addr,
    input  logic [31:0]       ma_wdata,
    output logic [31:0]       ma_rdata,
    output logic              ma_done,

    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_we,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,

    output logic              stall_if,
    output logic              stall_ma
);

    localparam int CNT_W = $clog2(MAX_STREAK + 1);
    localparam logic [CNT_W-1:0] STREAK_LIMIT = CNT_W'(MAX_STREAK);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ_IF  = 3'd1,
        REQ_MA  = 3'd2,
        RESP_IF = 3'd3,
        RESP_MA = 3'd4
    } state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  streak_cnt_reg;
    logic              mem_req_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [3:0]        mem_we_reg;
    logic [31:0]       mem_wdata_reg;

    logic              pick_ma;
    logic              pick_if;
    logic [CNT_W-1:0]  streak_inc;

    // Arbitration decision, only acted upon in IDLE. The streak counter
    // saturates at the limit, so "not at limit" is the same as "below limit".
    always_comb begin
        pick_ma    = ma_req && (!if_req || (streak_cnt_reg != STREAK_LIMIT));
        pick_if    = if_req && !pick_ma;
        streak_inc = (streak_cnt_reg == STREAK_LIMIT) ? streak_cnt_reg
                                                      : streak_cnt_reg + CNT_W'(1);
    end

    // Single sequential FSM. The request towards memory is fully registered,
    // so nothing from the requester side reaches mem_* combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            streak_cnt_reg <= '0;
            mem_req_reg    <= 1'b0;
            mem_addr_reg   <= '0;
            mem_we_reg     <= '0;
            mem_wdata_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_ma) begin
                        state_reg     <= REQ_MA;
                        mem_req_reg   <= 1'b1;
                        mem_addr_reg  <= ma_addr;
                        mem_we_reg    <= ma_we;
                        mem_wdata_reg <= ma_wdata;
                        // Only a data grant that made fetch wait extends the streak.
                        streak_cnt_reg <= if_req ? streak_inc : '0;
                    end else if (pick_if) begin
                        state_reg      <= REQ_IF;
                        mem_req_reg    <= 1'b1;
                        mem_addr_reg   <= if_addr;
                        mem_we_reg     <= '0;
                        mem_wdata_reg  <= '0;
                        streak_cnt_reg <= '0;
                    end
                end
                REQ_IF: begin
                    if (mem_gnt) begin
                        state_reg   <= RESP_IF;
                        mem_req_reg <= 1'b0;
                    end
                end
                REQ_MA: begin
                    if (mem_gnt) begin
                        state_reg   <= RESP_MA;
                        mem_req_reg <= 1'b0;
                    end
                end
                // A response arriving in the grant cycle is seen while still in
                // REQ_x, so it never completes the transaction.
                RESP_IF: begin
                    if (mem_rvalid) begin
                        state_reg <= IDLE;
                    end
                end
                RESP_MA: begin
                    if (mem_rvalid) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    mem_req_reg <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_we    = mem_we_reg;
    assign mem_wdata = mem_wdata_reg;

    // Completion and read data come straight from the memory response.
    assign if_rvalid = (state_reg == RESP_IF) && mem_rvalid;
    assign ma_done   = (state_reg == RESP_MA) && mem_rvalid;
    assign if_rdata  = mem_rdata;
    assign ma_rdata  = mem_rdata;

    assign stall_if  = if_req && !if_rvalid;
    assign stall_ma  = ma_req && !ma_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 32;
    localparam int MAX_STREAK = 4;
    localparam int PH_IDLE = 0;
    localparam int PH_REQ  = 1;
    localparam int PH_RESP = 2;

    logic              clk;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              if_rvalid;
    logic              ma_req;
    logic [3:0]        ma_we;
    logic [ADDR_W-1:0] ma_addr;
    logic [31:0]       ma_wdata;
    logic [31:0]       ma_rdata;
    logic              ma_done;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_we;
    logic [31:0]       mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;
    logic              stall_if;
    logic              stall_ma;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .MAX_STREAK(MAX_STREAK)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_rvalid(if_rvalid),
        .ma_req(ma_req), .ma_we(ma_we), .ma_addr(ma_addr), .ma_wdata(ma_wdata),
        .ma_rdata(ma_rdata), .ma_done(ma_done),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_ma(stall_ma)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------------------------------------------------------- scoring
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
    } txn_t;

    txn_t if_q[$];
    txn_t ma_q[$];

    // Reference memory (updated from expected transactions) and the memory
    // responder's own storage (updated from what the DUT actually drives).
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] mem_arr [logic [31:0]];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] we,
                                          input logic [31:0] d);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Reference model state: transaction phase, who owns it, fetch-wait streak.
    int   ph = PH_IDLE;
    txn_t cur;
    bit   cur_ma = 1'b0;
    int   streak = 0;
    int   grant_log[$];
    int   if_done_cnt = 0, ma_done_cnt = 0;
    int   last_if_done_cyc = 0, last_ma_done_cyc = 0;
    logic [31:0] last_if_rdata = 0;
    bit   if_done_flag = 1'b0, ma_done_flag = 1'b0;

    // ---------------------------------------------------------------- requesters
    bit if_en = 1'b0, ma_en = 1'b0;
    int if_gap = 3, ma_gap = 3;

    task automatic issue_if(input logic [31:0] a);
        txn_t t;
        t.addr = a; t.we = 4'b0; t.wdata = 32'b0;
        if_addr = a;
        if_q.push_back(t);
        if_req = 1'b1;
    endtask

    task automatic issue_ma(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        txn_t t;
        t.addr = a; t.we = w; t.wdata = d;
        ma_addr = a; ma_we = w; ma_wdata = d;
        ma_q.push_back(t);
        ma_req = 1'b1;
    endtask

    initial begin : if_drv
        if_req = 1'b0;
        if_addr = '0;
        forever begin
            @(posedge clk); #1;
            if (if_req && if_done_flag) begin
                if_req = 1'b0;
                if_done_flag = 1'b0;
            end
            if (!if_req && if_en && rst && $urandom_range(if_gap, 0) == 0)
                issue_if({26'b0, 4'($urandom_range(15, 0)), 2'b00});
        end
    end

    initial begin : ma_drv
        ma_req = 1'b0;
        ma_we = '0;
        ma_addr = '0;
        ma_wdata = '0;
        forever begin
            @(posedge clk); #1;
            if (ma_req && ma_done_flag) begin
                ma_req = 1'b0;
                ma_done_flag = 1'b0;
            end
            if (!ma_req && ma_en && rst && $urandom_range(ma_gap, 0) == 0)
                issue_ma({26'b0, 4'($urandom_range(15, 0)), 2'b00},
                         ($urandom_range(1, 0) == 1) ? 4'($urandom_range(15, 1)) : 4'b0,
                         $urandom);
        end
    end

    // ---------------------------------------------------------------- memory
    int gnt_min = 0, gnt_max = 0, rv_min = 0, rv_max = 0;
    int stray_idle_pct = 0;
    bit stray_gnt = 1'b0;
    bit force_stray = 1'b0;

    initial begin : mem_model
        bit outst;
        int gcnt;
        int rcnt;
        logic [31:0] a;
        logic [3:0]  w;
        logic [31:0] d;
        logic [31:0] old;
        outst = 1'b0; gcnt = -1; rcnt = 0; a = '0; w = '0; d = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata = $urandom;
            if (!rst) begin
                outst = 1'b0;
                gcnt = -1;
            end else if (outst) begin
                if (rcnt == 0) begin
                    old = mem_arr.exists(a) ? mem_arr[a] : dflt(a);
                    mem_rvalid = 1'b1;
                    mem_rdata = old;
                    if (w != 4'b0) mem_arr[a] = merge(old, w, d);
                    outst = 1'b0;
                end else begin
                    rcnt--;
                end
            end else begin
                if (mem_req) begin
                    if (gcnt < 0) gcnt = $urandom_range(gnt_max, gnt_min);
                    if (gcnt == 0) begin
                        mem_gnt = 1'b1;
                        a = mem_addr; w = mem_we; d = mem_wdata;
                        outst = 1'b1;
                        gcnt = -1;
                        rcnt = $urandom_range(rv_max, rv_min);
                        if (stray_gnt) mem_rvalid = 1'b1;
                    end else begin
                        gcnt--;
                    end
                end
                if (!mem_gnt && (force_stray || $urandom_range(99, 0) < stray_idle_pct))
                    mem_rvalid = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- monitor
    initial begin : monitor
        bit e_if, e_ma, win_ma;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("rst_mem_req",   32'(mem_req),   32'd0);
                chk("rst_mem_addr",  mem_addr,       32'd0);
                chk("rst_mem_we",    32'(mem_we),    32'd0);
                chk("rst_mem_wdata", mem_wdata,      32'd0);
                chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
                chk("rst_ma_done",   32'(ma_done),   32'd0);
                chk("rst_stall_if",  32'(stall_if),  32'd0);
                chk("rst_stall_ma",  32'(stall_ma),  32'd0);
                continue;
            end
            chk("mem_req", 32'(mem_req), 32'(ph == PH_REQ));
            if (ph == PH_REQ) begin
                chk("mem_addr",  mem_addr,     cur.addr);
                chk("mem_we",    32'(mem_we),  32'(cur.we));
                chk("mem_wdata", mem_wdata,    cur.wdata);
            end
            e_if = (ph == PH_RESP) && !cur_ma && mem_rvalid;
            e_ma = (ph == PH_RESP) &&  cur_ma && mem_rvalid;
            chk("if_rvalid", 32'(if_rvalid), 32'(e_if));
            chk("ma_done",   32'(ma_done),   32'(e_ma));
            chk("stall_if",  32'(stall_if),  32'(if_req && !e_if));
            chk("stall_ma",  32'(stall_ma),  32'(ma_req && !e_ma));
            if (e_if) begin
                chk("if_rdata", if_rdata, ref_read(cur.addr));
                $display("txn fetch addr=0x%08h rdata=0x%08h cycle=%0d", cur.addr, if_rdata, cyc);
                last_if_rdata = if_rdata;
                last_if_done_cyc = cyc;
                if_done_cnt++;
                if_done_flag = 1'b1;
                if (if_q.size() > 0) void'(if_q.pop_front());
            end
            if (e_ma) begin
                if (cur.we == 4'b0) chk("ma_rdata", ma_rdata, ref_read(cur.addr));
                else ref_mem[cur.addr] = merge(ref_read(cur.addr), cur.we, cur.wdata);
                $display("txn data  addr=0x%08h we=%b wdata=0x%08h rdata=0x%08h cycle=%0d",
                         cur.addr, cur.we, cur.wdata, ma_rdata, cyc);
                last_ma_done_cyc = cyc;
                ma_done_cnt++;
                ma_done_flag = 1'b1;
                if (ma_q.size() > 0) void'(ma_q.pop_front());
            end
            case (ph)
                PH_IDLE: begin
                    if (if_req || ma_req) begin
                        win_ma = ma_req && (!if_req || streak < MAX_STREAK);
                        if (win_ma) begin
                            checks++;
                            if (ma_q.size() == 0) begin
                                errors++;
                                $display("FAIL sb_ma_empty: got no queued data request, expected one");
                            end else cur = ma_q[0];
                            cur_ma = 1'b1;
                            streak = if_req ? streak + 1 : 0;
                        end else begin
                            checks++;
                            if (if_q.size() == 0) begin
                                errors++;
                                $display("FAIL sb_if_empty: got no queued fetch request, expected one");
                            end else cur = if_q[0];
                            cur.we = 4'b0;
                            cur.wdata = 32'b0;
                            cur_ma = 1'b0;
                            streak = 0;
                        end
                        grant_log.push_back(win_ma ? 1 : 0);
                        ph = PH_REQ;
                    end
                end
                PH_REQ:  if (mem_gnt) ph = PH_RESP;
                default: if (mem_rvalid) ph = PH_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------- helpers
    task automatic do_reset();
        @(posedge clk); #2;
        if_en = 1'b0; ma_en = 1'b0;
        rst = 1'b0;
        if_req = 1'b0; ma_req = 1'b0;
        if_q.delete(); ma_q.delete();
        ph = PH_IDLE; streak = 0;
        if_done_flag = 1'b0; ma_done_flag = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
    endtask

    task automatic wait_idle(input int bound, input string name);
        int n;
        n = 0;
        while (!(ph == PH_IDLE && !if_req && !ma_req && if_q.size() == 0 && ma_q.size() == 0)
               && n < bound) begin
            @(posedge clk); #3;
            n++;
        end
        checks++;
        if (n >= bound) begin
            errors++;
            $display("FAIL timeout_%s: got still busy after %0d cycles, expected idle", name, n);
        end
    endtask

    task automatic wait_done(input bit is_ma, input int start, input int bound, input string name);
        int n;
        n = 0;
        while (((is_ma ? ma_done_cnt : if_done_cnt) == start) && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= bound) begin
            errors++;
            $display("FAIL timeout_%s: got no completion in %0d cycles, expected one", name, n);
        end
    endtask

    task automatic set_mem(input int gmin, input int gmax, input int rmin, input int rmax,
                           input int spct, input bit sgnt);
        gnt_min = gmin; gnt_max = gmax; rv_min = rmin; rv_max = rmax;
        stray_idle_pct = spct; stray_gnt = sgnt;
    endtask

    // ---------------------------------------------------------------- main
    initial begin : main
        int t0, c0, n;
        int exp_order[6];
        exp_order = '{1, 1, 1, 1, 0, 1};
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;

        // Single fetch, best-case memory.
        set_mem(0, 0, 0, 0, 0, 1'b0);
        ref_mem[32'h100] = 32'hDEAD_BEEF;
        mem_arr[32'h100] = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        t0 = cyc; c0 = if_done_cnt;
        issue_if(32'h100);
        wait_done(1'b0, c0, 20, "single_fetch");
        chk("fetch_latency", 32'(last_if_done_cyc - t0), 32'd2);
        chk("fetch_data", last_if_rdata, 32'hDEAD_BEEF);
        wait_idle(20, "single_fetch");

        // Halfword store with three grant wait cycles, then fetch it back.
        set_mem(3, 3, 0, 0, 0, 1'b0);
        @(posedge clk); #1;
        t0 = cyc; c0 = ma_done_cnt;
        issue_ma(32'h2004, 4'b0011, 32'h0000_ABCD);
        wait_done(1'b1, c0, 30, "store");
        chk("store_latency", 32'(last_ma_done_cyc - t0), 32'd5);
        wait_idle(20, "store");
        set_mem(0, 0, 0, 0, 0, 1'b0);
        @(posedge clk); #1;
        c0 = if_done_cnt;
        issue_if(32'h2004);
        wait_done(1'b0, c0, 20, "store_readback");
        chk("store_readback", last_if_rdata, 32'h5A5A_ABCD);
        wait_idle(20, "store_readback");

        // Contention: both held continuously from the same cycle, streak at 0.
        grant_log.delete();
        if_gap = 0; ma_gap = 0;
        @(negedge clk);
        if_en = 1'b1; ma_en = 1'b1;
        n = 0;
        while (grant_log.size() < 6 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if_en = 1'b0; ma_en = 1'b0;
        wait_idle(100, "contention");
        chk("contention_grants", 32'(grant_log.size() >= 6), 32'd1);
        if (grant_log.size() >= 6)
            for (int i = 0; i < 6; i++) chk($sformatf("grant_order_%0d", i),
                                            32'(grant_log[i]), 32'(exp_order[i]));

        // Reset while a data read sits in its response phase, then a stray rvalid.
        set_mem(0, 0, 6, 6, 0, 1'b0);
        @(posedge clk); #1;
        c0 = ma_done_cnt;
        issue_ma(32'h40, 4'b0, 32'h0);
        n = 0;
        while (ph != PH_RESP && n < 20) begin
            @(posedge clk); #3;
            n++;
        end
        chk("reached_resp_ma", 32'(ph == PH_RESP), 32'd1);
        do_reset();
        force_stray = 1'b1;
        @(posedge clk); #2;
        force_stray = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        chk("abort_no_done", 32'(ma_done_cnt - c0), 32'd0);
        chk("abort_mem_req", 32'(mem_req), 32'd0);
        set_mem(0, 0, 0, 0, 0, 1'b0);
        @(posedge clk); #1;
        c0 = if_done_cnt;
        issue_if(32'h80);
        wait_done(1'b0, c0, 20, "post_reset_fetch");
        chk("post_reset_data", last_if_rdata, 32'h5A5A_A525);
        wait_idle(20, "post_reset");

        // Responses in IDLE, REQ wait and the grant cycle are all ignored.
        set_mem(2, 2, 2, 2, 50, 1'b1);
        @(posedge clk); #1;
        t0 = cyc; c0 = if_done_cnt;
        issue_if(32'h24);
        wait_done(1'b0, c0, 30, "ignored_fetch");
        chk("ignored_fetch_latency", 32'(last_if_done_cyc - t0), 32'd6);
        wait_idle(20, "ignored_fetch");
        @(posedge clk); #1;
        t0 = cyc; c0 = ma_done_cnt;
        issue_ma(32'h28, 4'b1111, 32'h1234_5678);
        wait_done(1'b1, c0, 30, "ignored_store");
        chk("ignored_store_latency", 32'(last_ma_done_cyc - t0), 32'd6);
        wait_idle(20, "ignored_store");

        // Random traffic against the reference model.
        set_mem(0, 3, 0, 3, 20, 1'b1);
        if_gap = 3; ma_gap = 2;
        @(negedge clk);
        if_en = 1'b1; ma_en = 1'b1;
        repeat (3000) @(negedge clk);
        if_en = 1'b0; ma_en = 1'b0;
        wait_idle(200, "random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got simulation still running at 1 ms, expected finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
